twiddle_table_builder: RTL and testbench

- Builds the forward and inverse twiddle tables that feed the twiddle factor generator's tf_in / tf_in_inv buses.
- Sequentially computes powers of a primitive 2D-th root of unity (psi) and its inverse modulo Q.
- Writes each power into the bit-reversed table slot, then holds both tables stable until the next build.
- Sits between the configuration/register interface and the twiddle factor generator.

---
 rtl/twiddle_table_builder.sv | 81 ++++++++
 tb/tb_twiddle_table_builder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_table_builder.sv
// twiddle_table_builder: fills bit-reversed forward/inverse twiddle tables with successive powers of psi mod Q.
// Optional TWIDDLE_ROOT_CHECK_EN adds root_err, flagging psi^D or psi_inv^D != -1 mod Q.
module twiddle_table_builder #(
  parameter int N = 17,
  parameter int D = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   root,
  input  logic [N-1:0]   root_inv,
  input  logic [N-1:0]   modulus,
  output logic           busy,
  output logic           done,
  output logic           valid,
`ifdef TWIDDLE_ROOT_CHECK_EN
  output logic           root_err,
`endif
  output logic [D*N-1:0] tf_in,
  output logic [D*N-1:0] tf_in_inv
);
  localparam int L = $clog2(D);
  localparam logic [1:0] IDLE = 2'd0, BUILD = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [L-1:0] cnt;
  logic [N-1:0] acc, acc_inv, root_r, root_inv_r, mod_r, acc_n, acc_inv_n;
  logic [2*N-1:0] mod_w;
  function automatic logic [L-1:0] brv(input logic [L-1:0] x);
    for (int i = 0; i < L; i++) brv[i] = x[L-1-i];
  endfunction
  assign mod_w = {{N{1'b0}}, mod_r};
  assign acc_n = N'(({{N{1'b0}}, acc} * {{N{1'b0}}, root_r}) % mod_w);
  assign acc_inv_n = N'(({{N{1'b0}}, acc_inv} * {{N{1'b0}}, root_inv_r}) % mod_w);
  assign busy = state == BUILD;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      acc_inv <= '0;
      root_r <= '0;
      root_inv_r <= '0;
      mod_r <= '0;
      valid <= 1'b0;
      tf_in <= '0;
      tf_in_inv <= '0;
`ifdef TWIDDLE_ROOT_CHECK_EN
      root_err <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (start) begin
        state <= BUILD;
        cnt <= '0;
        acc <= N'(1);
        acc_inv <= N'(1);
        root_r <= root;
        root_inv_r <= root_inv;
        mod_r <= modulus;
        valid <= 1'b0;
`ifdef TWIDDLE_ROOT_CHECK_EN
        root_err <= 1'b0;
`endif
      end
    end else if (state == BUILD) begin
      tf_in[brv(cnt)*N +: N] <= acc;
      tf_in_inv[brv(cnt)*N +: N] <= acc_inv;
      acc <= acc_n;
      acc_inv <= acc_inv_n;
      cnt <= cnt + 1'b1;
      if (cnt == L'(D-1)) begin
        state <= DONE;
        valid <= 1'b1;
`ifdef TWIDDLE_ROOT_CHECK_EN
        // acc_n here is psi^D, so the flag is already settled during the DONE cycle
        root_err <= (acc_n != mod_r - 1'b1) || (acc_inv_n != mod_r - 1'b1);
`endif
      end
    end else
      state <= IDLE;
endmodule

// File: tb/tb_twiddle_table_builder.sv
// tb_twiddle_table_builder: checks small (N=5,D=4) and default (N=17,D=16) builders against a power/bit-reverse model.
module tb_twiddle_table_builder;
  logic clk = 0, rst = 1, s_start = 0, l_start = 0;
  logic [4:0] s_root = 0, s_rinv = 0, s_mod = 0;
  logic [16:0] l_root = 0, l_rinv = 0, l_mod = 0;
  logic s_busy, s_done, s_valid, l_busy, l_done, l_valid;
  logic [19:0] s_tf, s_tfi;
  logic [271:0] l_tf, l_tfi;
`ifdef TWIDDLE_ROOT_CHECK_EN
  logic s_err, l_err;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  twiddle_table_builder #(.N(5), .D(4)) u_s (
    .clk(clk), .rst(rst), .start(s_start), .root(s_root), .root_inv(s_rinv), .modulus(s_mod),
    .busy(s_busy), .done(s_done), .valid(s_valid),
`ifdef TWIDDLE_ROOT_CHECK_EN
    .root_err(s_err),
`endif
    .tf_in(s_tf), .tf_in_inv(s_tfi));
  twiddle_table_builder u_l (
    .clk(clk), .rst(rst), .start(l_start), .root(l_root), .root_inv(l_rinv), .modulus(l_mod),
    .busy(l_busy), .done(l_done), .valid(l_valid),
`ifdef TWIDDLE_ROOT_CHECK_EN
    .root_err(l_err),
`endif
    .tf_in(l_tf), .tf_in_inv(l_tfi));
  function automatic longint pw(longint b, int e, longint q);
    longint r = 1 % q;
    for (int i = 0; i < e; i++) r = (r * b) % q;
    return r;
  endfunction
  function automatic int brv(int k, int l);
    int r = 0;
    for (int i = 0; i < l; i++) if (k[i]) r |= 1 << (l - 1 - i);
    return r;
  endfunction
  function automatic logic [271:0] tab(longint r, longint q, int d, int n);
    logic [271:0] t = '0;
    int l = $clog2(d);
    for (int k = d - 1; k >= 0; k--) t = (t << n) | 272'(pw(r, brv(k, l), q));
    return t;
  endfunction
  function automatic logic rerr(longint r, longint ri, longint q, int d);
    return pw(r, d, q) != q - 1 || pw(ri, d, q) != q - 1;
  endfunction
  task automatic s_build(input logic [4:0] r, ri, q, output int lat, output int bc, output int vc);
    @(posedge clk); #1;
    s_root = r; s_rinv = ri; s_mod = q; s_start = 1;
    @(posedge clk); #1;
    s_start = 0; lat = 1; bc = int'(s_busy); vc = int'(!s_valid);
    while (!s_done && lat < 100) begin
      @(posedge clk); #1;
      lat++; bc += int'(s_busy); vc += int'(!s_valid);
    end
  endtask
  task automatic l_build(input logic [16:0] r, ri, q, output int lat);
    @(posedge clk); #1;
    l_root = r; l_rinv = ri; l_mod = q; l_start = 1;
    @(posedge clk); #1;
    l_start = 0; lat = 1;
    while (!l_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({s_busy, s_done, s_valid} !== 3'b000) begin errors++; $display("FAIL reset_s_flags got %b exp 000", {s_busy, s_done, s_valid}); end
    checks++;
    if ({s_tf, s_tfi} !== '0) begin errors++; $display("FAIL reset_s_tables got %h %h exp 0", s_tf, s_tfi); end
    checks++;
    if ({l_busy, l_done, l_valid} !== 3'b000 || {l_tf, l_tfi} !== '0) begin errors++; $display("FAIL reset_l got flags %b", {l_busy, l_done, l_valid}); end
    rst = 0;
  endtask
  task automatic test_normal;
    int lat, bc, vc;
    s_build(5'd2, 5'd9, 5'd17, lat, bc, vc);
    checks++;
    if (lat !== 5 || bc !== 4) begin errors++; $display("FAIL normal_timing got lat=%0d busy=%0d exp 5 4", lat, bc); end
    checks++;
    if (s_valid !== 1'b1) begin errors++; $display("FAIL normal_valid got %b exp 1", s_valid); end
    checks++;
    if (s_tf !== {5'd8, 5'd2, 5'd4, 5'd1}) begin errors++; $display("FAIL normal_tf got %h exp %h", s_tf, {5'd8, 5'd2, 5'd4, 5'd1}); end
    checks++;
    if (s_tfi !== {5'd15, 5'd9, 5'd13, 5'd1}) begin errors++; $display("FAIL normal_tfi got %h exp %h", s_tfi, {5'd15, 5'd9, 5'd13, 5'd1}); end
`ifdef TWIDDLE_ROOT_CHECK_EN
    checks++;
    if (s_err !== 1'b0) begin errors++; $display("FAIL normal_root_err got %b exp 0", s_err); end
`endif
    @(posedge clk); #1;
    checks++;
    if (s_done !== 1'b0 || s_valid !== 1'b1) begin errors++; $display("FAIL normal_pulse got done=%b valid=%b exp 0 1", s_done, s_valid); end
  endtask
  task automatic test_rebuild;
    int lat, bc, vc;
    logic [271:0] e, ei;
    e = tab(4, 17, 4, 5); ei = tab(13, 17, 4, 5);
    s_build(5'd4, 5'd13, 5'd17, lat, bc, vc);
    checks++;
    if (vc !== 4 || lat !== 5) begin errors++; $display("FAIL rebuild_valid_low got %0d lat=%0d exp 4 5", vc, lat); end
    checks++;
    if (s_tf !== e[19:0] || s_tfi !== ei[19:0]) begin errors++; $display("FAIL rebuild_tables got %h %h exp %h %h", s_tf, s_tfi, e[19:0], ei[19:0]); end
`ifdef TWIDDLE_ROOT_CHECK_EN
    checks++;
    if (s_err !== 1'b1) begin errors++; $display("FAIL rebuild_root_err got %b exp 1", s_err); end
`endif
  endtask
  task automatic test_start_busy;
    int dn = 0;
    @(posedge clk); #1;
    s_root = 2; s_rinv = 9; s_mod = 17; s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin s_root = 3; s_start = 1; end
      if (c == 2) s_start = 0;
      @(posedge clk); #1;
      dn += int'(s_done);
    end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", dn); end
    checks++;
    if (s_tf !== {5'd8, 5'd2, 5'd4, 5'd1} || s_tfi !== {5'd15, 5'd9, 5'd13, 5'd1}) begin errors++; $display("FAIL busy_tables got %h %h", s_tf, s_tfi); end
    s_root = 2;
  endtask
  task automatic test_start_in_done;
    int lat, bc, vc;
    s_build(5'd2, 5'd9, 5'd17, lat, bc, vc);
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    checks++;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL done_start_1 got busy=%b exp 0", s_busy); end
    @(posedge clk); #1;
    checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b1) begin errors++; $display("FAIL done_start_2 got busy=%b valid=%b exp 0 1", s_busy, s_valid); end
  endtask
  task automatic test_reset_mid;
    int dn = 0, lat, bc, vc;
    @(posedge clk); #1;
    s_root = 2; s_rinv = 9; s_mod = 17; s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    checks++;
    if ({s_busy, s_done, s_valid} !== 3'b000 || {s_tf, s_tfi} !== '0) begin errors++; $display("FAIL midreset_clear got flags %b tf %h", {s_busy, s_done, s_valid}, s_tf); end
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 8; c++) begin @(posedge clk); #1; dn += int'(s_done); end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", dn); end
    s_build(5'd2, 5'd9, 5'd17, lat, bc, vc);
    checks++;
    if (lat !== 5 || s_tf !== {5'd8, 5'd2, 5'd4, 5'd1} || s_tfi !== {5'd15, 5'd9, 5'd13, 5'd1}) begin errors++; $display("FAIL midreset_rebuild got lat=%0d %h %h", lat, s_tf, s_tfi); end
  endtask
  task automatic test_random_small;
    int lat, bc, vc;
    logic [4:0] q, r, ri;
    logic [271:0] e, ei;
    for (int n = 0; n < 6; n++) begin
      q = 5'($urandom_range(1, 15) * 2 + 1);
      r = 5'($urandom_range(0, int'(q) - 1));
      ri = 5'($urandom_range(0, int'(q) - 1));
      e = tab(r, q, 4, 5); ei = tab(ri, q, 4, 5);
      s_build(r, ri, q, lat, bc, vc);
      checks++;
      if (lat !== 5 || s_tf !== e[19:0] || s_tfi !== ei[19:0]) begin errors++; $display("FAIL rand_small q=%0d r=%0d ri=%0d got lat=%0d %h %h exp %h %h", q, r, ri, lat, s_tf, s_tfi, e[19:0], ei[19:0]); end
`ifdef TWIDDLE_ROOT_CHECK_EN
      checks++;
      if (s_err !== rerr(r, ri, q, 4)) begin errors++; $display("FAIL rand_small_root_err got %b exp %b", s_err, rerr(r, ri, q, 4)); end
`endif
    end
  endtask
  task automatic test_default;
    int lat;
    logic [16:0] q, r, ri;
    logic [271:0] e, ei;
    for (int n = 0; n < 3; n++) begin
      q = n == 0 ? 17'd65537 : 17'($urandom_range(1, 65535) * 2 + 1);
      r = n == 0 ? 17'd4096 : 17'($urandom_range(0, int'(q) - 1));
      ri = n == 0 ? 17'd65521 : 17'($urandom_range(0, int'(q) - 1));
      e = tab(r, q, 16, 17); ei = tab(ri, q, 16, 17);
      l_build(r, ri, q, lat);
      checks++;
      if (lat !== 17 || l_valid !== 1'b1) begin errors++; $display("FAIL default_timing got lat=%0d valid=%b exp 17 1", lat, l_valid); end
      checks++;
      if (l_tf !== e || l_tfi !== ei) begin errors++; $display("FAIL default_tables q=%0d r=%0d ri=%0d", q, r, ri); end
`ifdef TWIDDLE_ROOT_CHECK_EN
      checks++;
      if (l_err !== rerr(r, ri, q, 16)) begin errors++; $display("FAIL default_root_err got %b exp %b", l_err, rerr(r, ri, q, 16)); end
`endif
    end
  endtask
  initial begin
    test_reset;
    test_normal;
    test_rebuild;
    test_start_busy;
    test_start_in_done;
    test_reset_mid;
    test_random_small;
    test_default;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
